// File: rtl/spi_target_regfile.sv
// SPI mode-0 target with a byte-wide register file, oversampled entirely in the
// system clock domain. Byte0 = {rw, addr[6:0]}; following bytes are data, addr auto-increments.
module spi_target_regfile #(
  parameter int REG_COUNT   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   spi_sck,
  input  logic                   spi_cs_n,
  input  logic                   spi_mosi,
  output logic                   spi_miso,
  output logic                   spi_miso_oe,
  output logic [8*REG_COUNT-1:0] regs_o,
  output logic                   wr_pulse_o,
  output logic [6:0]             wr_addr_o,
  output logic                   frame_done_o
);
  localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, CMD, DATA} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q, sync_valid_q;
  logic                   sck_prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q   <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sync_valid_q <= '0;
      sck_prev_q   <= 1'b0;
    end else begin
      sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sync_valid_q <= {sync_valid_q[SYNC_STAGES-2:0], 1'b1};
      sck_prev_q   <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  logic sck_s, cs_s, mosi_s, sync_ok, sck_rise, sck_fall;
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  // The synchronizer's reset value of cs_n=1 is not a real sample; wait until it has flushed.
  assign sync_ok  = sync_valid_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_in_q, shift_in_d;
  logic [7:0]  shift_out_q, shift_out_d;
  logic [6:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic        byte_done_q, byte_done_d;
  logic        miso_q, miso_d;
  logic        oe_q, oe_d;
  logic        wr_pulse_q, wr_pulse_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic        frame_done_q, frame_done_d;
  logic        wr_en;
  logic [7:0]  regs_q [REG_COUNT];

  function automatic logic in_range(input logic [6:0] a);
    return (a >> AW) == 7'd0;
  endfunction

  logic [7:0]    byte_in;
  logic [AW-1:0] addr_lo_inc;
  logic [6:0]    addr_inc;
  logic [7:0]    rd_cmd, rd_inc;

  assign byte_in     = {shift_in_q, mosi_s};
  assign addr_lo_inc = addr_q[AW-1:0] + AW'(1);
  // In-range addresses wrap modulo REG_COUNT; out-of-range ones count on in 7 bits.
  assign addr_inc    = in_range(addr_q) ? 7'(addr_lo_inc) : addr_q + 7'd1;
  assign rd_cmd      = in_range(byte_in[6:0]) ? regs_q[byte_in[AW-1:0]] : 8'h00;
  assign rd_inc      = in_range(addr_inc) ? regs_q[addr_inc[AW-1:0]] : 8'h00;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WAIT_IDLE;
      bit_cnt_q    <= '0;
      shift_in_q   <= '0;
      shift_out_q  <= '0;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      byte_done_q  <= 1'b0;
      miso_q       <= 1'b0;
      oe_q         <= 1'b0;
      wr_pulse_q   <= 1'b0;
      wr_addr_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_in_q   <= shift_in_d;
      shift_out_q  <= shift_out_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      byte_done_q  <= byte_done_d;
      miso_q       <= miso_d;
      oe_q         <= oe_d;
      wr_pulse_q   <= wr_pulse_d;
      wr_addr_q    <= wr_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_in_d   = shift_in_q;
    shift_out_d  = shift_out_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    byte_done_d  = byte_done_q;
    miso_d       = miso_q;
    wr_pulse_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      WAIT_IDLE: if (sync_ok && cs_s) state_d = IDLE;
      IDLE: begin
        if (!cs_s) begin
          state_d     = CMD;
          bit_cnt_d   = '0;
          byte_done_d = 1'b0;
          shift_out_d = '0;
        end
      end
      default: begin
        // cs_n rising takes priority over any sck edge seen in the same cycle.
        if (cs_s) begin
          state_d      = IDLE;
          miso_d       = 1'b0;
          frame_done_d = byte_done_q;
        end else if (sck_rise) begin
          shift_in_d = byte_in[6:0];
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_done_d = 1'b1;
            if (state_q == CMD) begin
              rw_d        = byte_in[7];
              addr_d      = byte_in[6:0];
              state_d     = DATA;
              shift_out_d = byte_in[7] ? rd_cmd : 8'h00;
            end else if (rw_q) begin
              addr_d      = addr_inc;
              shift_out_d = rd_inc;
            end else begin
              if (in_range(addr_q)) begin
                wr_en      = 1'b1;
                wr_pulse_d = 1'b1;
                wr_addr_d  = addr_q;
              end
              addr_d = addr_inc;
            end
          end
        end else if (sck_fall && state_q == DATA) begin
          miso_d      = shift_out_q[7];
          shift_out_d = {shift_out_q[6:0], 1'b0};
        end
      end
    endcase
    oe_d = (state_d == CMD) || (state_d == DATA);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 8'h00;
    end else if (wr_en) begin
      regs_q[addr_q[AW-1:0]] <= byte_in;
    end
  end

  for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_regs_out
    assign regs_o[8*gi +: 8] = regs_q[gi];
  end

  assign spi_miso     = miso_q;
  assign spi_miso_oe  = oe_q;
  assign wr_pulse_o   = wr_pulse_q;
  assign wr_addr_o    = wr_addr_q;
  assign frame_done_o = frame_done_q;
endmodule
